pixel_depth_writer: RTL and testbench

//  Downstream of the edge rasterizer. Accepts the (x,y,depth,color) pixel stream and its write strobe.

---
 rtl/pixel_depth_writer_pkg.sv | 33 +++
 rtl/pixel_depth_writer_fifo.sv | 58 +++++
 rtl/pixel_depth_writer.sv | 168 ++++++++++++++++
 tb/tb_pixel_depth_writer.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pixel_depth_writer_pkg.sv
// Shared definitions for the pixel depth writer: field widths, the queued
// pixel record, FSM state encoding and a saturating counter helper.
// Ports: none (package).
package pixel_depth_writer_pkg;

  localparam int COORD_W = 16;
  localparam int DEPTH_W = 2;
  localparam int COLOR_W = 16;

  // Depth written during a frame clear: farthest possible value.
  localparam logic [DEPTH_W-1:0] CLEAR_DEPTH = 2'b11;

  // One queued pixel, 50 bits wide.
  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic [DEPTH_W-1:0] depth;
    logic [COLOR_W-1:0] color;
  } pixel_t;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_READ    = 3'd1,
    ST_COMPARE = 3'd2,
    ST_WRITE   = 3'd3,
    ST_CLEAR   = 3'd4
  } state_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/pixel_depth_writer_fifo.sv
// Purpose: synchronous FIFO of pixel records with full/empty/count status.
// Latency: a pushed entry is visible on pop_data the cycle after the push.
// Backpressure: push while full and pop while empty are ignored.
// Ports: clock, reset_n; push/push_data in; pop in, pop_data out (head entry);
//        full, empty, count status out.
module pixel_depth_writer_fifo
  import pixel_depth_writer_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             push,
  input  pixel_t           push_data,
  input  logic             pop,
  output pixel_t           pop_data,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  pixel_t             mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic               do_push;
  logic               do_pop;

  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign pop_data = mem[rd_ptr];

  // Storage needs no reset; only the pointers and count define validity.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/pixel_depth_writer.sv
// Purpose: queue rasterized pixels, depth-test against the Z-buffer and write
//          survivors to Z-buffer + framebuffer; also runs frame clear and done.
// Latency: pop -> read 1 cycle, write 3 cycles after pop; clear 1 addr/cycle.
// Backpressure: out_sig_stall when FIFO nearly full or clear pending/active;
//               pixels arriving on a full FIFO are dropped (sticky overflow).
// Ports: clock/reset_n; clear, pixel strobe + (x,y,depth,color), rasterize-done
//        in; stall/overflow/frame_done status out; shared memory address,
//        Z-buffer read/write and framebuffer write ports; pass counter out.
module pixel_depth_writer
  import pixel_depth_writer_pkg::*;
#(
  parameter int          FB_WIDTH    = 320,
  parameter int          FB_HEIGHT   = 240,
  parameter int          ADDR_W      = 17,
  parameter int          FIFO_DEPTH  = 4,
  parameter logic [15:0] CLEAR_COLOR = 16'hF000
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                in_sig_clear,
  input  logic                in_sig_write_pixel,
  input  logic                in_sig_rasterize_done,
  input  logic [COORD_W-1:0]  in_pixel_x,
  input  logic [COORD_W-1:0]  in_pixel_y,
  input  logic [DEPTH_W-1:0]  in_pixel_depth,
  input  logic [COLOR_W-1:0]  in_pixel_color,
  output logic                out_sig_stall,
  output logic                out_sig_overflow,
  output logic                out_sig_frame_done,
  output logic [ADDR_W-1:0]   out_mem_addr,
  output logic                out_zbuf_rd_en,
  input  logic [DEPTH_W-1:0]  in_zbuf_rd_data,
  output logic                out_zbuf_wr_en,
  output logic [DEPTH_W-1:0]  out_zbuf_wr_data,
  output logic                out_fb_wr_en,
  output logic [COLOR_W-1:0]  out_fb_wr_data,
  output logic [15:0]         out_pixels_written
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_WIDTH * FB_HEIGHT - 1);

  state_t               state;
  pixel_t               push_pix;
  pixel_t               head;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [CNT_W-1:0]     fifo_count;
  logic                 clear_pending;
  logic                 done_pending;
  logic [DEPTH_W-1:0]   cur_depth;
  logic [COLOR_W-1:0]   cur_color;
  logic                 idle;
  logic                 pop;
  logic                 start_clear;
  logic                 fire_done;
  logic                 on_screen;
  logic [ADDR_W-1:0]    pixel_addr;

  assign push_pix = {in_pixel_x, in_pixel_y, in_pixel_depth, in_pixel_color};

  pixel_depth_writer_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (in_sig_write_pixel),
    .push_data (push_pix),
    .pop       (pop),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign idle = (state == ST_IDLE);
  // A pending clear waits for the queue to drain; queued pixels go first.
  assign pop         = idle & ~fifo_empty;
  assign start_clear = idle & fifo_empty & clear_pending;
  // Done is held back while a clear is about to start so the pulse always
  // follows every pixel that was queued ahead of it.
  assign fire_done   = idle & fifo_empty & ~clear_pending & done_pending;

  assign on_screen  = (head.x < COORD_W'(FB_WIDTH)) && (head.y < COORD_W'(FB_HEIGHT));
  assign pixel_addr = ADDR_W'(head.y) * ADDR_W'(FB_WIDTH) + ADDR_W'(head.x);

  assign out_sig_stall = (fifo_count >= CNT_W'(FIFO_DEPTH - 1)) | clear_pending |
                         (state == ST_CLEAR);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state              <= ST_IDLE;
      clear_pending      <= 1'b0;
      done_pending       <= 1'b0;
      cur_depth          <= '0;
      cur_color          <= '0;
      out_sig_overflow   <= 1'b0;
      out_sig_frame_done <= 1'b0;
      out_mem_addr       <= '0;
      out_zbuf_rd_en     <= 1'b0;
      out_zbuf_wr_en     <= 1'b0;
      out_zbuf_wr_data   <= '0;
      out_fb_wr_en       <= 1'b0;
      out_fb_wr_data     <= '0;
      out_pixels_written <= '0;
    end else begin
      out_zbuf_rd_en     <= 1'b0;
      out_sig_frame_done <= fire_done;
      done_pending       <= in_sig_rasterize_done | (done_pending & ~fire_done);

      if (in_sig_clear && !clear_pending && state != ST_CLEAR) clear_pending <= 1'b1;
      if (in_sig_write_pixel && fifo_full) out_sig_overflow <= 1'b1;

      case (state)
        ST_IDLE: begin
          if (start_clear) begin
            state              <= ST_CLEAR;
            clear_pending      <= 1'b0;
            out_sig_overflow   <= 1'b0;
            out_pixels_written <= '0;
            out_mem_addr       <= '0;
            out_zbuf_wr_en     <= 1'b1;
            out_zbuf_wr_data   <= CLEAR_DEPTH;
            out_fb_wr_en       <= 1'b1;
            out_fb_wr_data     <= CLEAR_COLOR;
          end else if (pop && on_screen) begin
            // Off-screen pixels are popped and simply not followed up.
            state          <= ST_READ;
            out_mem_addr   <= pixel_addr;
            out_zbuf_rd_en <= 1'b1;
            cur_depth      <= head.depth;
            cur_color      <= head.color;
          end
        end
        ST_READ: begin
          // Z-buffer read is presented this cycle; data arrives in COMPARE.
          state <= ST_COMPARE;
        end
        ST_COMPARE: begin
          if (cur_depth <= in_zbuf_rd_data) begin
            state              <= ST_WRITE;
            out_zbuf_wr_en     <= 1'b1;
            out_zbuf_wr_data   <= cur_depth;
            out_fb_wr_en       <= 1'b1;
            out_fb_wr_data     <= cur_color;
            out_pixels_written <= sat_inc16(out_pixels_written);
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_WRITE: begin
          state          <= ST_IDLE;
          out_zbuf_wr_en <= 1'b0;
          out_fb_wr_en   <= 1'b0;
        end
        ST_CLEAR: begin
          if (out_mem_addr == LAST_ADDR) begin
            state          <= ST_IDLE;
            out_zbuf_wr_en <= 1'b0;
            out_fb_wr_en   <= 1'b0;
          end else begin
            out_mem_addr <= out_mem_addr + ADDR_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pixel_depth_writer.sv
module tb_pixel_depth_writer;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_sig_clear = 1'b0;
  logic        in_sig_write_pixel = 1'b0;
  logic        in_sig_rasterize_done = 1'b0;
  logic [15:0] in_pixel_x = '0;
  logic [15:0] in_pixel_y = '0;
  logic [1:0]  in_pixel_depth = '0;
  logic [15:0] in_pixel_color = '0;
  logic        out_sig_stall;
  logic        out_sig_overflow;
  logic        out_sig_frame_done;
  logic [16:0] out_mem_addr;
  logic        out_zbuf_rd_en;
  logic [1:0]  in_zbuf_rd_data = '0;
  logic        out_zbuf_wr_en;
  logic [1:0]  out_zbuf_wr_data;
  logic        out_fb_wr_en;
  logic [15:0] out_fb_wr_data;
  logic [15:0] out_pixels_written;

  int total  = 0;
  int passed = 0;

  // Z-buffer model: every read returns stored_depth one cycle later.
  logic [1:0]  stored_depth = 2'b11;

  // Memory-side activity seen by the monitor (only the monitor writes these).
  int          rd_seen = 0;
  int          wr_seen = 0;
  logic [16:0] last_wr_addr = '0;

  pixel_depth_writer dut (
    .clock                 (clock),
    .reset_n               (reset_n),
    .in_sig_clear          (in_sig_clear),
    .in_sig_write_pixel    (in_sig_write_pixel),
    .in_sig_rasterize_done (in_sig_rasterize_done),
    .in_pixel_x            (in_pixel_x),
    .in_pixel_y            (in_pixel_y),
    .in_pixel_depth        (in_pixel_depth),
    .in_pixel_color        (in_pixel_color),
    .out_sig_stall         (out_sig_stall),
    .out_sig_overflow      (out_sig_overflow),
    .out_sig_frame_done    (out_sig_frame_done),
    .out_mem_addr          (out_mem_addr),
    .out_zbuf_rd_en        (out_zbuf_rd_en),
    .in_zbuf_rd_data       (in_zbuf_rd_data),
    .out_zbuf_wr_en        (out_zbuf_wr_en),
    .out_zbuf_wr_data      (out_zbuf_wr_data),
    .out_fb_wr_en          (out_fb_wr_en),
    .out_fb_wr_data        (out_fb_wr_data),
    .out_pixels_written    (out_pixels_written)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (out_zbuf_rd_en) in_zbuf_rd_data <= stored_depth;
  end

  always @(negedge clock) begin
    if (out_zbuf_rd_en) rd_seen++;
    if (out_fb_wr_en) begin
      wr_seen++;
      last_wr_addr = out_mem_addr;
    end
  end

  // Move to just after the next falling edge: outputs are stable, and inputs
  // driven here are sampled by the following rising edge.
  task automatic step();
    @(negedge clock);
    #1;
  endtask

  task automatic set_pixel(input logic [15:0] x, input logic [15:0] y,
                           input logic [1:0] d, input logic [15:0] c);
    in_sig_write_pixel = 1'b1;
    in_pixel_x = x;
    in_pixel_y = y;
    in_pixel_depth = d;
    in_pixel_color = c;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) step();
    total++; if (out_zbuf_rd_en !== 1'b0) $display("FAIL reset_rd_en: got %b want 0", out_zbuf_rd_en); else passed++;
    total++; if (out_zbuf_wr_en !== 1'b0) $display("FAIL reset_zwr_en: got %b want 0", out_zbuf_wr_en); else passed++;
    total++; if (out_fb_wr_en !== 1'b0) $display("FAIL reset_fbwr_en: got %b want 0", out_fb_wr_en); else passed++;
    total++; if (out_mem_addr !== 17'd0) $display("FAIL reset_addr: got %0d want 0", out_mem_addr); else passed++;
    total++; if (out_pixels_written !== 16'd0) $display("FAIL reset_count: got %0d want 0", out_pixels_written); else passed++;
    total++; if (out_sig_overflow !== 1'b0) $display("FAIL reset_overflow: got %b want 0", out_sig_overflow); else passed++;
    total++; if (out_sig_stall !== 1'b0) $display("FAIL reset_stall: got %b want 0", out_sig_stall); else passed++;
    total++; if (out_sig_frame_done !== 1'b0) $display("FAIL reset_frame_done: got %b want 0", out_sig_frame_done); else passed++;
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_clear();
    int n = 0;
    int errs = 0;
    int fd = 0;
    in_sig_clear = 1'b1;
    step();
    in_sig_clear = 1'b0;
    total++; if (out_sig_stall !== 1'b1) $display("FAIL clear_pending_stall: got %b want 1", out_sig_stall); else passed++;
    for (int i = 0; i < 80000; i++) begin
      step();
      if (out_sig_frame_done) fd++;
      if (out_fb_wr_en) begin
        if (out_mem_addr !== n[16:0] || out_zbuf_wr_en !== 1'b1 || out_zbuf_wr_data !== 2'b11 ||
            out_fb_wr_data !== 16'hF000 || out_sig_stall !== 1'b1)
          errs++;
        n++;
      end else if (n > 0) begin
        break;
      end
    end
    total++; if (n != 76800) $display("FAIL clear_write_count: got %0d want 76800", n); else passed++;
    total++; if (errs != 0) $display("FAIL clear_write_values: got %0d bad writes want 0", errs); else passed++;
    total++; if (fd != 0) $display("FAIL clear_frame_done: got %0d pulses want 0", fd); else passed++;
    total++; if (out_sig_stall !== 1'b0) $display("FAIL clear_end_stall: got %b want 0", out_sig_stall); else passed++;
    total++; if (out_pixels_written !== 16'd0) $display("FAIL clear_count: got %0d want 0", out_pixels_written); else passed++;
  endtask

  task automatic test_pass();
    stored_depth = 2'b11;
    set_pixel(16'd100, 16'd25, 2'd0, 16'hFF00);
    step();
    in_sig_write_pixel = 1'b0;
    step();
    total++; if (out_zbuf_rd_en !== 1'b1) $display("FAIL pass_rd_en: got %b want 1", out_zbuf_rd_en); else passed++;
    total++; if (out_mem_addr !== 17'd8100) $display("FAIL pass_rd_addr: got %0d want 8100", out_mem_addr); else passed++;
    step();
    total++; if (out_zbuf_rd_en !== 1'b0 || out_fb_wr_en !== 1'b0) $display("FAIL pass_compare_idle: got rd=%b wr=%b want 0 0", out_zbuf_rd_en, out_fb_wr_en); else passed++;
    step();
    total++; if (out_zbuf_wr_en !== 1'b1 || out_fb_wr_en !== 1'b1) $display("FAIL pass_wr_en: got z=%b fb=%b want 1 1", out_zbuf_wr_en, out_fb_wr_en); else passed++;
    total++; if (out_mem_addr !== 17'd8100) $display("FAIL pass_wr_addr: got %0d want 8100", out_mem_addr); else passed++;
    total++; if (out_zbuf_wr_data !== 2'd0) $display("FAIL pass_wr_depth: got %0d want 0", out_zbuf_wr_data); else passed++;
    total++; if (out_fb_wr_data !== 16'hFF00) $display("FAIL pass_wr_color: got %h want ff00", out_fb_wr_data); else passed++;
    total++; if (out_pixels_written !== 16'd1) $display("FAIL pass_count: got %0d want 1", out_pixels_written); else passed++;
    step();
    total++; if (out_fb_wr_en !== 1'b0) $display("FAIL pass_wr_single: got %b want 0", out_fb_wr_en); else passed++;
  endtask

  task automatic test_fail();
    int w0 = wr_seen;
    stored_depth = 2'b01;
    set_pixel(16'd100, 16'd25, 2'd2, 16'h00FF);
    step();
    in_sig_write_pixel = 1'b0;
    step();
    total++; if (out_zbuf_rd_en !== 1'b1 || out_mem_addr !== 17'd8100) $display("FAIL fail_rd: got en=%b addr=%0d want 1 8100", out_zbuf_rd_en, out_mem_addr); else passed++;
    repeat (4) step();
    total++; if (wr_seen != w0) $display("FAIL fail_no_write: got %0d writes want 0", wr_seen - w0); else passed++;
    total++; if (out_pixels_written !== 16'd1) $display("FAIL fail_count: got %0d want 1", out_pixels_written); else passed++;
    stored_depth = 2'b11;
  endtask

  task automatic test_offscreen();
    int r0 = rd_seen;
    int w0 = wr_seen;
    set_pixel(16'd400, 16'd10, 2'd0, 16'h0F0F);
    step();
    in_sig_write_pixel = 1'b0;
    repeat (5) step();
    total++; if (rd_seen != r0) $display("FAIL offscreen_no_read: got %0d reads want 0", rd_seen - r0); else passed++;
    total++; if (wr_seen != w0) $display("FAIL offscreen_no_write: got %0d writes want 0", wr_seen - w0); else passed++;
    total++; if (out_pixels_written !== 16'd1) $display("FAIL offscreen_count: got %0d want 1", out_pixels_written); else passed++;
  endtask

  // One busy pixel, then five back-to-back strobes: the FSM is mid-pixel, so
  // the queue fills and the fifth strobe of the burst is dropped.
  task automatic test_back_to_back();
    int w0 = wr_seen;
    logic [5:0] stall_seen = '0;
    logic ovf_before = 1'b0;
    logic ovf_after = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (i == 0) set_pixel(16'd10, 16'd1, 2'd0, 16'hA000);
      else        set_pixel(16'(19 + i), 16'd2, 2'd0, 16'(16'hB000 + i));
      step();
      stall_seen[i] = out_sig_stall;
      if (i == 4) ovf_before = out_sig_overflow;
      if (i == 5) ovf_after = out_sig_overflow;
    end
    in_sig_write_pixel = 1'b0;
    total++; if (stall_seen !== 6'b111000) $display("FAIL burst_stall: got %b want 111000", stall_seen); else passed++;
    total++; if (ovf_before !== 1'b0) $display("FAIL burst_overflow_early: got %b want 0", ovf_before); else passed++;
    total++; if (ovf_after !== 1'b1) $display("FAIL burst_overflow: got %b want 1", ovf_after); else passed++;
    repeat (40) step();
    total++; if (wr_seen - w0 != 5) $display("FAIL burst_writes: got %0d want 5", wr_seen - w0); else passed++;
    total++; if (out_pixels_written !== 16'd6) $display("FAIL burst_count: got %0d want 6", out_pixels_written); else passed++;
    total++; if (last_wr_addr !== 17'd663) $display("FAIL burst_last_addr: got %0d want 663", last_wr_addr); else passed++;
    total++; if (out_sig_overflow !== 1'b1 || out_sig_stall !== 1'b0) $display("FAIL burst_final_flags: got ovf=%b stall=%b want 1 0", out_sig_overflow, out_sig_stall); else passed++;
  endtask

  task automatic test_done_same_cycle();
    int wr_cyc = 0;
    int fd_cyc = 0;
    int fd_n = 0;
    set_pixel(16'd50, 16'd50, 2'd0, 16'h1234);
    in_sig_rasterize_done = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      step();
      in_sig_write_pixel = 1'b0;
      in_sig_rasterize_done = 1'b0;
      if (out_fb_wr_en) wr_cyc = c;
      if (out_sig_frame_done) begin
        fd_n++;
        fd_cyc = c;
      end
    end
    total++; if (wr_cyc != 4) $display("FAIL done_write_cycle: got %0d want 4", wr_cyc); else passed++;
    total++; if (fd_n != 1) $display("FAIL done_pulse_count: got %0d want 1", fd_n); else passed++;
    total++; if (fd_cyc != 6) $display("FAIL done_pulse_cycle: got %0d want 6", fd_cyc); else passed++;
  endtask

  task automatic test_reset_in_write();
    int r0;
    for (int i = 0; i < 3; i++) begin
      set_pixel(16'(60 + i), 16'd3, 2'd0, 16'hC0C0);
      step();
    end
    in_sig_write_pixel = 1'b0;
    step();
    total++; if (out_fb_wr_en !== 1'b1) $display("FAIL rst_mid_in_write: got %b want 1", out_fb_wr_en); else passed++;
    reset_n = 1'b0;
    step();
    total++; if (out_zbuf_wr_en !== 1'b0 || out_fb_wr_en !== 1'b0 || out_zbuf_rd_en !== 1'b0) $display("FAIL rst_mid_enables: got z=%b fb=%b rd=%b want 0 0 0", out_zbuf_wr_en, out_fb_wr_en, out_zbuf_rd_en); else passed++;
    total++; if (out_mem_addr !== 17'd0) $display("FAIL rst_mid_addr: got %0d want 0", out_mem_addr); else passed++;
    total++; if (out_zbuf_wr_data !== 2'd0 || out_fb_wr_data !== 16'd0) $display("FAIL rst_mid_data: got z=%0d fb=%h want 0 0", out_zbuf_wr_data, out_fb_wr_data); else passed++;
    total++; if (out_pixels_written !== 16'd0) $display("FAIL rst_mid_count: got %0d want 0", out_pixels_written); else passed++;
    total++; if (out_sig_overflow !== 1'b0 || out_sig_stall !== 1'b0 || out_sig_frame_done !== 1'b0) $display("FAIL rst_mid_flags: got ovf=%b stall=%b fd=%b want 0 0 0", out_sig_overflow, out_sig_stall, out_sig_frame_done); else passed++;
    reset_n = 1'b1;
    r0 = rd_seen;
    repeat (8) step();
    total++; if (rd_seen != r0) $display("FAIL rst_mid_fifo_empty: got %0d reads want 0", rd_seen - r0); else passed++;
  endtask

  initial begin
    test_reset();
    test_clear();
    test_pass();
    test_fail();
    test_offscreen();
    test_back_to_back();
    test_done_same_cycle();
    test_reset_in_write();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
